alien_bomb_engine: RTL

Manages up to NUM_BOMBS enemy bombs that fall down the screen toward the player: accepts drop requests from the alien-formation logic, advances every live bomb downward at a fixed tick rate, and retires bombs at the screen bottom or on contact with the player sprite. It sits beside the player block in the VGA peripheral. It drives a combinational per-pixel bomb layer into the colour mux, and produces a hit pulse plus a hit counter for game-state logic.

---
 rtl/alien_bomb_engine_if.sv | 17 +
 rtl/alien_bomb_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alien_bomb_engine_if.sv
// Drop-request handshake between the alien-formation logic and the bomb engine.
// Signals:
//   drop_valid  master->slave  request to spawn a bomb
//   drop_row    master->slave  starting top row of the new bomb
//   drop_col    master->slave  column of the new bomb
//   drop_ready  slave->master  at least one bomb slot is free
interface alien_bomb_engine_if;
    localparam int unsigned COORD_W = 12;

    logic               drop_valid;
    logic [COORD_W-1:0] drop_row;
    logic [COORD_W-1:0] drop_col;
    logic               drop_ready;

    modport master (output drop_valid, output drop_row, output drop_col, input drop_ready);
    modport slave  (input drop_valid, input drop_row, input drop_col, output drop_ready);
endinterface

// File: rtl/alien_bomb_engine.sv
// Enemy bomb manager: spawns bombs on request, moves them down once per motion
// tick, retires them at the screen bottom or on player contact, and drives a
// zero-latency per-pixel bomb layer.
// Optional feature macro: BOMB_HIT_DETECT_EN (player hit check, hit pulse, hit counter).
// Ports:
//   clk, rst      pixel clock, asynchronous active-high reset
//   drop          drop handshake (slave side): drop_valid/drop_row/drop_col in, drop_ready out
//   pixel_row, pixel_column   current VGA scan position
//   player_row, player_col    player sprite reference corner
//   bomb_busy     per-slot live flags
//   bomb_active, bomb_output  combinational bomb layer for the colour mux
//   player_hit    one-cycle pulse when bombs hit the player
//   hit_count     saturating hit counter
module alien_bomb_engine #(
    parameter int unsigned NUM_BOMBS   = 4,
    parameter int unsigned STEP_CYCLES = 250000,
    parameter int unsigned STEP_PIX    = 2,
    parameter int unsigned BOMB_LEN    = 3,
    parameter int unsigned BOTTOM_ROW  = 479
) (
    input  logic                  clk,
    input  logic                  rst,
    alien_bomb_engine_if.slave    drop,
    input  logic [11:0]           pixel_row,
    input  logic [11:0]           pixel_column,
    input  logic [11:0]           player_row,
    input  logic [11:0]           player_col,
    output logic [NUM_BOMBS-1:0]  bomb_busy,
    output logic                  bomb_active,
    output logic [3:0]            bomb_output,
    output logic                  player_hit,
    output logic [7:0]            hit_count
);
    localparam int unsigned CW     = 12;
    localparam int unsigned XW     = 13;
    localparam int unsigned TICK_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SUM_W  = 9;

    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [NUM_BOMBS-1:0] busy_q, busy_d;
    logic [CW-1:0]        row_q [NUM_BOMBS];
    logic [CW-1:0]        row_d [NUM_BOMBS];
    logic [CW-1:0]        col_q [NUM_BOMBS];
    logic [CW-1:0]        col_d [NUM_BOMBS];
    logic                 ready_q, ready_d;
    logic                 accept;
    logic                 loaded;
    logic [NUM_BOMBS-1:0] overlap;
    logic [NUM_BOMBS-1:0] hit_vec;

    assign tick       = (tick_cnt_q == TICK_W'(STEP_CYCLES - 1));
    assign accept     = drop.drop_valid && ready_q;
    assign drop.drop_ready = ready_q;
    assign bomb_busy  = busy_q;

`ifdef BOMB_HIT_DETECT_EN
    // Bomb column strictly inside the sprite and bomb rows intersecting sprite rows +1..+10.
    always_comb begin
        overlap = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            overlap[i] = (XW'(player_col) < XW'(col_q[i]))
                      && (XW'(col_q[i]) < XW'(player_col) + XW'(16))
                      && (XW'(row_q[i]) < XW'(player_row) + XW'(11))
                      && (XW'(row_q[i]) + XW'(BOMB_LEN) > XW'(player_row) + XW'(1));
        end
    end
`else
    assign overlap = '0;
`endif

    // Slot update: tick motion/retirement, then drop load into the lowest slot free before this edge.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        busy_d     = busy_q;
        row_d      = row_q;
        col_d      = col_q;
        hit_vec    = '0;
        loaded     = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (tick && busy_q[i]) begin
                if (overlap[i]) begin
                    busy_d[i]  = 1'b0;
                    hit_vec[i] = 1'b1;
                end else if (XW'(row_q[i]) + XW'(STEP_PIX) > XW'(BOTTOM_ROW)) begin
                    busy_d[i] = 1'b0;
                end else begin
                    row_d[i] = row_q[i] + CW'(STEP_PIX);
                end
            end
        end
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (accept && !busy_q[i] && !loaded) begin
                busy_d[i] = 1'b1;
                row_d[i]  = drop.drop_row;
                col_d[i]  = drop.drop_col;
                loaded    = 1'b1;
            end
        end
        ready_d = |(~busy_d);
    end

    // Slot and tick state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            busy_q     <= '0;
            ready_q    <= 1'b1;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

`ifdef BOMB_HIT_DETECT_EN
    logic             hit_q, hit_d;
    logic [7:0]       hit_count_q, hit_count_d;
    logic [SUM_W-1:0] hit_sum;

    // Count all slots hitting on this edge; saturate at 255.
    always_comb begin
        hit_sum = SUM_W'(hit_count_q);
        for (int i = 0; i < NUM_BOMBS; i++) begin
            hit_sum = hit_sum + SUM_W'(hit_vec[i]);
        end
        hit_d       = |hit_vec;
        hit_count_d = (hit_sum > SUM_W'(255)) ? 8'hFF : hit_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q       <= 1'b0;
            hit_count_q <= '0;
        end else begin
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign player_hit = hit_q;
    assign hit_count  = hit_count_q;
`else
    logic unused_hit_inputs;
    assign unused_hit_inputs = ^{hit_vec, player_row, player_col};
    assign player_hit = 1'b0;
    assign hit_count  = '0;
`endif

    // Pixel layer: one column wide, BOMB_LEN rows tall, from the registered slot state.
    always_comb begin
        bomb_active = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (busy_q[i] && (pixel_column == col_q[i])
                && (XW'(pixel_row) >= XW'(row_q[i]))
                && (XW'(pixel_row) < XW'(row_q[i]) + XW'(BOMB_LEN))) begin
                bomb_active = 1'b1;
            end
        end
        bomb_output = {4{bomb_active}};
    end
endmodule
